// File: rtl/fetch_path.sv
// rtl/fetch_path.sv - instruction fetch stage with IF/ID register, stall hold buffer and redirect discard
module fetch_path (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src_D,
    input  logic [31:0] pc_br_D,
    input  logic        stall_D,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] inst_D,
    output logic [31:0] pc_plus4_D,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HELD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_F, pc_F_nx;
    logic [31:0] hold_inst, hold_inst_nx;
    logic [31:0] hold_pc4, hold_pc4_nx;
    logic [31:0] redirect_pc, redirect_pc_nx;
    logic [31:0] inst_nx, pc4_nx;
    logic [31:0] pc_F_plus4;
    logic        redirect;

    assign redirect    = pc_src_D & ~stall_D;
    assign pc_F_plus4  = pc_F + 32'd4;
    assign imem_req    = (state != HELD);
    assign imem_addr   = pc_F;
    assign fetch_stall = imem_req & ~imem_ready;

    always_comb begin
        state_nx       = state;
        pc_F_nx        = pc_F;
        hold_inst_nx   = hold_inst;
        hold_pc4_nx    = hold_pc4;
        redirect_pc_nx = redirect_pc;
        inst_nx        = inst_D;
        pc4_nx         = pc_plus4_D;

        // A redirect or an unstalled cycle with nothing to deliver clears IF/ID
        if (redirect) begin
            inst_nx = 32'd0;
            pc4_nx  = 32'd0;
        end

        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_F_nx = pc_br_D;
                    end else if (stall_D) begin
                        hold_inst_nx = imem_rdata;
                        hold_pc4_nx  = pc_F_plus4;
                        pc_F_nx      = pc_F_plus4;
                        state_nx     = HELD;
                    end else begin
                        inst_nx = imem_rdata;
                        pc4_nx  = pc_F_plus4;
                        pc_F_nx = pc_F_plus4;
                    end
                end else if (redirect) begin
                    redirect_pc_nx = pc_br_D;
                    state_nx       = DISCARD;
                end else if (!stall_D) begin
                    inst_nx = 32'd0;
                    pc4_nx  = 32'd0;
                end
            end
            HELD: begin
                if (redirect) begin
                    pc_F_nx  = pc_br_D;
                    state_nx = FETCH;
                end else if (!stall_D) begin
                    inst_nx  = hold_inst;
                    pc4_nx   = hold_pc4;
                    state_nx = FETCH;
                end
            end
            DISCARD: begin
                if (redirect)
                    redirect_pc_nx = pc_br_D;
                if (!stall_D) begin
                    inst_nx = 32'd0;
                    pc4_nx  = 32'd0;
                end
                // The youngest redirect target wins if one arrives with the stale ack
                if (imem_ready) begin
                    pc_F_nx  = redirect ? pc_br_D : redirect_pc;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc_F        <= 32'd0;
            hold_inst   <= 32'd0;
            hold_pc4    <= 32'd0;
            redirect_pc <= 32'd0;
            inst_D      <= 32'd0;
            pc_plus4_D  <= 32'd0;
        end else begin
            state       <= state_nx;
            pc_F        <= pc_F_nx;
            hold_inst   <= hold_inst_nx;
            hold_pc4    <= hold_pc4_nx;
            redirect_pc <= redirect_pc_nx;
            inst_D      <= inst_nx;
            pc_plus4_D  <= pc4_nx;
        end
    end

endmodule

// File: tb/tb_fetch_path.sv
// tb/tb_fetch_path.sv - self-checking bench for fetch_path against a behavioural fetch model
module tb_fetch_path;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_src_D = 1'b0;
    logic [31:0] pc_br_D = 32'd0;
    logic        stall_D = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst_D;
    logic [31:0] pc_plus4_D;
    logic        fetch_stall;

    int checks = 0;
    int errors = 0;

    fetch_path dut (
        .clk(clk), .reset(rst), .pc_src_D(pc_src_D), .pc_br_D(pc_br_D),
        .stall_D(stall_D), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .inst_D(inst_D),
        .pc_plus4_D(pc_plus4_D), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    // Memory image: every word is its own address tagged with 0xA in the top nibble
    assign imem_rdata = imem_addr | 32'hA000_0000;

    // Behavioural model: a pending request, an optional one-word buffer, an optional
    // "ack still owed to a stale request" flag, and the IF/ID pair.
    logic [31:0] m_pc = 0, m_buf_i = 0, m_buf_p = 0, m_target = 0, m_inst = 0, m_pc4 = 0;
    bit          m_buffered = 0, m_stale = 0;

    always @(posedge clk or posedge rst) begin
        bit take;
        take = pc_src_D && !stall_D;
        if (rst) begin
            m_pc = 0; m_buf_i = 0; m_buf_p = 0; m_target = 0;
            m_inst = 0; m_pc4 = 0; m_buffered = 0; m_stale = 0;
        end else if (m_buffered) begin
            if (take) begin
                m_pc = pc_br_D; m_inst = 0; m_pc4 = 0; m_buffered = 0;
            end else if (!stall_D) begin
                m_inst = m_buf_i; m_pc4 = m_buf_p; m_buffered = 0;
            end
        end else if (m_stale) begin
            if (take) m_target = pc_br_D;
            if (take || !stall_D) begin m_inst = 0; m_pc4 = 0; end
            if (imem_ready) begin m_pc = m_target; m_stale = 0; end
        end else if (imem_ready) begin
            if (take) begin
                m_pc = pc_br_D; m_inst = 0; m_pc4 = 0;
            end else if (stall_D) begin
                m_buf_i = m_pc | 32'hA000_0000; m_buf_p = m_pc + 4; m_pc = m_pc + 4; m_buffered = 1;
            end else begin
                m_inst = m_pc | 32'hA000_0000; m_pc4 = m_pc + 4; m_pc = m_pc + 4;
            end
        end else if (take) begin
            m_target = pc_br_D; m_stale = 1; m_inst = 0; m_pc4 = 0;
        end else if (!stall_D) begin
            m_inst = 0; m_pc4 = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_imem_req", {31'd0, imem_req}, {31'd0, !m_buffered});
        check("model_imem_addr", imem_addr, m_pc);
        check("model_inst_D", inst_D, m_inst);
        check("model_pc_plus4_D", pc_plus4_D, m_pc4);
        check("model_fetch_stall", {31'd0, fetch_stall}, {31'd0, !m_buffered && !imem_ready});
    end

    task automatic step(input bit rdy, input bit stl, input bit src, input logic [31:0] br);
        imem_ready = rdy; stall_D = stl; pc_src_D = src; pc_br_D = br;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_req", {31'd0, imem_req}, 32'd1);
        check("reset_addr", imem_addr, 32'd0);
        check("reset_inst", inst_D, 32'd0);
        check("reset_pc4", pc_plus4_D, 32'd0);
        rst = 1'b0;

        // Zero-wait streaming
        step(1, 0, 0, 0);
        check("seq0_inst", inst_D, 32'hA000_0000);
        check("seq0_pc4", pc_plus4_D, 32'd4);
        step(1, 0, 0, 0);
        check("seq1_inst", inst_D, 32'hA000_0004);
        check("seq1_pc4", pc_plus4_D, 32'd8);
        step(1, 0, 0, 0);
        check("seq2_inst", inst_D, 32'hA000_0008);
        check("seq2_pc4", pc_plus4_D, 32'd12);
        step(1, 0, 0, 0);
        check("pre_stall_addr", imem_addr, 32'h10);

        // Stall while fetching 0x10
        repeat (3) step(1, 1, 0, 0);
        check("held_req", {31'd0, imem_req}, 32'd0);
        check("held_addr", imem_addr, 32'h14);
        check("held_inst_unchanged", inst_D, 32'hA000_000C);
        step(1, 0, 0, 0);
        check("unheld_inst", inst_D, 32'hA000_0010);
        check("unheld_pc4", pc_plus4_D, 32'h14);
        check("unheld_addr", imem_addr, 32'h14);

        // Redirect while 0x20 is waiting
        repeat (3) step(1, 0, 0, 0);
        check("wait_addr", imem_addr, 32'h20);
        step(0, 0, 1, 32'h400);
        check("discard_addr0", imem_addr, 32'h20);
        check("discard_inst0", inst_D, 32'd0);
        step(0, 0, 0, 0);
        check("discard_addr1", imem_addr, 32'h20);
        check("discard_stall", {31'd0, fetch_stall}, 32'd1);
        step(1, 0, 0, 0);
        check("after_discard_addr", imem_addr, 32'h400);
        check("after_discard_inst", inst_D, 32'd0);
        step(1, 0, 0, 0);
        check("target_inst", inst_D, 32'hA000_0400);

        // Branch presented under stall is ignored, then honoured
        step(1, 1, 1, 32'h800);
        check("stall_br_inst", inst_D, 32'hA000_0400);
        check("stall_br_addr", imem_addr, 32'h408);
        step(1, 0, 1, 32'h800);
        check("flush_inst", inst_D, 32'd0);
        check("flush_pc4", pc_plus4_D, 32'd0);
        check("flush_addr", imem_addr, 32'h800);

        // PC wraparound
        step(1, 0, 1, 32'hFFFF_FFFC);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        check("wrap_inst", inst_D, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4_D, 32'd0);
        check("wrap_addr1", imem_addr, 32'd0);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 {$urandom_range(0, 255), 2'b00});

        // Asynchronous reset in the middle of a discard
        step(0, 0, 1, 32'h100);
        step(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_addr", imem_addr, 32'd0);
        check("async_rst_inst", inst_D, 32'd0);
        check("async_rst_pc4", pc_plus4_D, 32'd0);
        check("async_rst_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1; stall_D = 1'b0; pc_src_D = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post_rst_inst", inst_D, 32'hA000_0000);
        check("post_rst_addr", imem_addr, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
